sobel_stream_filter: RTL and testbench

//  Parametrised streaming 3x3 Sobel edge filter; successor to the fixed-size Sobel top.

---
 rtl/sobel_pkg.sv | 18 +
 rtl/sobel_stream_filter_if.sv | 24 ++
 rtl/sobel_line_buffer.sv | 31 +++
 rtl/sobel_stream_filter.sv | 154 +++++++++++++++
 tb/tb_sobel_stream_filter.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/sobel_pkg.sv
// Shared types and helpers for the streaming Sobel filter.
package sobel_pkg;

    typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} sobel_state_e;

    // Kernels indexed [row][col], row 0 being the oldest line in the window.
    localparam int SOBEL_KX [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
    localparam int SOBEL_KY [3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};

    function automatic int grad_w(input int px_size);
        return px_size + 3;
    endfunction

    function automatic int sat_mag(input int mag, input int max_val);
        return (mag > max_val) ? max_val : mag;
    endfunction

endpackage

// File: rtl/sobel_stream_filter_if.sv
// Pixel stream bus of the Sobel filter; the threshold signal exists only
// when SOBEL_THRESHOLD_EN is defined.
interface sobel_stream_filter_if #(parameter int PX_SIZE = 8);
    logic [PX_SIZE-1:0] input_data;
    logic               input_data_valid;
    logic               input_ready;
    logic [PX_SIZE-1:0] output_data;
    logic               output_data_valid;
    logic               frame_done;
    logic               overflow;
`ifdef SOBEL_THRESHOLD_EN
    logic [PX_SIZE-1:0] threshold;

    modport slave  (input  input_data, input_data_valid, threshold,
                    output input_ready, output_data, output_data_valid, frame_done, overflow);
    modport master (output input_data, input_data_valid, threshold,
                    input  input_ready, output_data, output_data_valid, frame_done, overflow);
`else
    modport slave  (input  input_data, input_data_valid,
                    output input_ready, output_data, output_data_valid, frame_done, overflow);
    modport master (output input_data, input_data_valid,
                    input  input_ready, output_data, output_data_valid, frame_done, overflow);
`endif
endinterface

// File: rtl/sobel_line_buffer.sv
// One-line delay: circular RAM read before write on every shift, so the
// output is the pixel written DEPTH shifts earlier.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int PX_SIZE = 8,
    parameter int DEPTH   = 800
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               i_shift,
    input  logic [PX_SIZE-1:0] i_din,
    output logic [PX_SIZE-1:0] o_dout
);
    localparam int PW = $clog2(DEPTH);

    logic [PX_SIZE-1:0] r_mem [DEPTH];
    logic [PW-1:0]      r_ptr;

    assign o_dout = r_mem[r_ptr];

    always_ff @(posedge clk) begin
        if (i_shift) r_mem[r_ptr] <= i_din;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)      r_ptr <= '0;
        else if (i_shift) r_ptr <= (r_ptr == PW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
    end

endmodule

// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel filter with zeroed border and self-drain at frame end.
// Define SOBEL_THRESHOLD_EN to binarise the magnitude against bus.threshold.
module sobel_stream_filter
    import sobel_pkg::*;
#(
    parameter int PX_SIZE      = 8,
    parameter int IMAGE_WIDTH  = 800,
    parameter int IMAGE_HEIGHT = 533
) (
    input  logic                  clk,
    input  logic                  resetn,
    sobel_stream_filter_if.slave  bus
);
    localparam int STAGES = 2;
    localparam int GW     = grad_w(PX_SIZE);
    localparam int CW     = $clog2(IMAGE_WIDTH);
    localparam int RW     = $clog2(IMAGE_HEIGHT);
    localparam int NW     = $clog2(IMAGE_WIDTH + 2);

    sobel_state_e       r_state;
    logic [NW-1:0]      r_cnt;
    logic               r_ready, r_overflow;
    logic [CW-1:0]      r_in_col, r_oc_col;
    logic [RW-1:0]      r_in_row, r_oc_row;
    logic [STAGES:0]    r_vld_pipe;
    logic [STAGES-1:0]  r_bord, r_last;
    logic [PX_SIZE-1:0] r_win [3][3];
    logic signed [GW-1:0] r_gx, r_gy;
    logic [PX_SIZE-1:0] r_out;
    logic               r_frame_done;

    logic               w_accept, w_shift, w_ctr_vld, w_in_last, w_oc_border, w_oc_last;
    logic [PX_SIZE-1:0] w_px, w_lb0, w_lb1, w_pix;
    logic signed [GW-1:0] w_gx, w_gy;
    logic [GW-1:0]      w_mag;

    assign w_accept  = bus.input_data_valid & r_ready;
    assign w_shift   = w_accept | (r_state == DRAIN);
    assign w_ctr_vld = (w_accept & (r_state == RUN)) | (r_state == DRAIN);
    assign w_px      = (r_state == DRAIN) ? '0 : bus.input_data;
    assign w_in_last = (r_in_row == RW'(IMAGE_HEIGHT - 1)) && (r_in_col == CW'(IMAGE_WIDTH - 1));
    assign w_oc_last = (r_oc_row == RW'(IMAGE_HEIGHT - 1)) && (r_oc_col == CW'(IMAGE_WIDTH - 1));
    assign w_oc_border = (r_oc_row == '0) || (r_oc_row == RW'(IMAGE_HEIGHT - 1)) ||
                         (r_oc_col == '0) || (r_oc_col == CW'(IMAGE_WIDTH - 1));

    assign bus.input_ready       = r_ready;
    assign bus.overflow          = r_overflow;
    assign bus.output_data       = r_out;
    assign bus.output_data_valid = r_vld_pipe[STAGES];
    assign bus.frame_done        = r_frame_done;

    sobel_line_buffer #(.PX_SIZE(PX_SIZE), .DEPTH(IMAGE_WIDTH)) u_lb0 (
        .clk(clk), .resetn(resetn), .i_shift(w_shift), .i_din(w_px),  .o_dout(w_lb0));
    sobel_line_buffer #(.PX_SIZE(PX_SIZE), .DEPTH(IMAGE_WIDTH)) u_lb1 (
        .clk(clk), .resetn(resetn), .i_shift(w_shift), .i_din(w_lb0), .o_dout(w_lb1));

    // Input-side sequencing: fill W+1 pixels, run, then feed W+1 zeros to flush.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_ready    <= 1'b1;
            r_overflow <= 1'b0;
            r_in_col   <= '0;
            r_in_row   <= '0;
        end else begin
            if (bus.input_data_valid && !r_ready) r_overflow <= 1'b1;
            if (w_accept) begin
                r_in_col <= (r_in_col == CW'(IMAGE_WIDTH - 1)) ? '0 : r_in_col + 1'b1;
                if (r_in_col == CW'(IMAGE_WIDTH - 1))
                    r_in_row <= (r_in_row == RW'(IMAGE_HEIGHT - 1)) ? '0 : r_in_row + 1'b1;
            end
            unique case (r_state)
                IDLE:  if (w_accept) begin r_state <= FILL; r_cnt <= NW'(1); end
                FILL:  if (w_accept) begin
                           r_cnt <= r_cnt + 1'b1;
                           if (r_cnt == NW'(IMAGE_WIDTH)) r_state <= RUN;
                       end
                RUN:   if (w_accept && w_in_last) begin
                           r_state <= DRAIN; r_ready <= 1'b0; r_cnt <= '0;
                       end
                DRAIN: begin
                           r_cnt <= r_cnt + 1'b1;
                           if (r_cnt == NW'(IMAGE_WIDTH)) begin r_state <= IDLE; r_ready <= 1'b1; end
                       end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        int sx, sy;
        sx = 0;
        sy = 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                sx += SOBEL_KX[r][c] * int'(r_win[r][c]);
                sy += SOBEL_KY[r][c] * int'(r_win[r][c]);
            end
        w_gx = GW'(sx);
        w_gy = GW'(sy);
    end

    always_comb begin
        int ax, ay;
        ax    = r_gx[GW-1] ? -int'(r_gx) : int'(r_gx);
        ay    = r_gy[GW-1] ? -int'(r_gy) : int'(r_gy);
        w_mag = GW'(ax + ay);
`ifdef SOBEL_THRESHOLD_EN
        w_pix = (w_mag >= {3'b000, bus.threshold}) ? '1 : '0;
`else
        w_pix = PX_SIZE'(sat_mag(int'(w_mag), (1 << PX_SIZE) - 1));
`endif
    end

    // Datapath registers carry no reset; border masking hides stale contents.
    always_ff @(posedge clk) begin
        if (w_shift) begin
            for (int r = 0; r < 3; r++) begin
                r_win[r][0] <= r_win[r][1];
                r_win[r][1] <= r_win[r][2];
            end
            r_win[0][2] <= w_lb1;
            r_win[1][2] <= w_lb0;
            r_win[2][2] <= w_px;
        end
        r_gx <= w_gx;
        r_gy <= w_gy;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_oc_col     <= '0;
            r_oc_row     <= '0;
            r_vld_pipe   <= '0;
            r_bord       <= '0;
            r_last       <= '0;
            r_out        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_vld_pipe   <= {r_vld_pipe[STAGES-1:0], w_ctr_vld};
            r_bord       <= {r_bord[0], w_oc_border};
            r_last       <= {r_last[0], w_oc_last};
            r_out        <= (r_vld_pipe[STAGES-1] && !r_bord[STAGES-1]) ? w_pix : '0;
            r_frame_done <= r_vld_pipe[STAGES-1] & r_last[STAGES-1];
            if (w_ctr_vld) begin
                r_oc_col <= (r_oc_col == CW'(IMAGE_WIDTH - 1)) ? '0 : r_oc_col + 1'b1;
                if (r_oc_col == CW'(IMAGE_WIDTH - 1))
                    r_oc_row <= (r_oc_row == RW'(IMAGE_HEIGHT - 1)) ? '0 : r_oc_row + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sobel_stream_filter.sv
// Scoreboard bench for sobel_stream_filter on an 8x6 frame; expected pixels
// come from a direct Sobel model of each driven image.
module tb_sobel_stream_filter;
    localparam int W    = 8;
    localparam int H    = 6;
    localparam int NPIX = W * H;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    sobel_stream_filter_if #(.PX_SIZE(8)) bus ();
    sobel_stream_filter #(.PX_SIZE(8), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) dut (
        .clk(clk), .resetn(resetn), .bus(bus));

    int n_chk = 0, n_err = 0;
    int cyc = 0, acc_cyc = 0, first_cyc = 0;
    int fd_cnt = 0, frames_exp = 0;
    int thr = 128;
    bit seen_first = 0, mon_en = 1;
    int img [NPIX];
    int q_data [$];
    bit q_last [$];

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int px(input int r, input int c);
        return img[r * W + c];
    endfunction

    task automatic push_model();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                int e, gx, gy, mag;
                e = 0;
                if (r > 0 && r < H - 1 && c > 0 && c < W - 1) begin
                    gx = (px(r-1,c+1) + 2*px(r,c+1) + px(r+1,c+1)) - (px(r-1,c-1) + 2*px(r,c-1) + px(r+1,c-1));
                    gy = (px(r+1,c-1) + 2*px(r+1,c) + px(r+1,c+1)) - (px(r-1,c-1) + 2*px(r-1,c) + px(r-1,c+1));
                    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_THRESHOLD_EN
                    e = (mag >= thr) ? 255 : 0;
`else
                    e = (mag > 255) ? 255 : mag;
`endif
                end
                q_data.push_back(e);
                q_last.push_back(r == H - 1 && c == W - 1);
            end
        frames_exp++;
    endtask

    task automatic fill_flat(input int v);
        for (int i = 0; i < NPIX; i++) img[i] = v;
    endtask

    task automatic fill_step(input int lo, input int hi);
        for (int i = 0; i < NPIX; i++) img[i] = ((i % W) < 4) ? lo : hi;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < NPIX; i++) img[i] = int'($urandom_range(255));
    endtask

    task automatic wait_ready();
        for (int t = 0; t < 64 && !bus.input_ready; t++) begin @(posedge clk); #1; end
        if (!bus.input_ready) check("ready_wait", int'(bus.input_ready), 1);
    endtask

    // Drives the first n pixels of img; only complete frames are scored.
    task automatic send_frame(input int gap_pct, input bit hold_drain, input int n);
        if (n == NPIX) push_model();
        for (int i = 0; i < n; i++) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                bus.input_data_valid = 1'b0;
                @(posedge clk); #1;
            end
            wait_ready();
            bus.input_data       = 8'(img[i]);
            bus.input_data_valid = 1'b1;
            @(posedge clk); #1;
            if (i == W + 1) acc_cyc = cyc;
        end
        if (hold_drain) begin
            for (int k = 0; k < 3; k++) begin
                bus.input_data = 8'hAA;
                check("ready_in_drain", int'(bus.input_ready), 0);
                @(posedge clk); #1;
            end
        end
        bus.input_data_valid = 1'b0;
    endtask

    task automatic drain_wait();
        for (int t = 0; t < 200 && q_data.size() != 0; t++) begin @(posedge clk); #1; end
        check("sb_drained", q_data.size(), 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en && bus.output_data_valid) begin
            check("sb_avail", int'(q_data.size() != 0), 1);
            if (q_data.size() != 0) begin
                int e;
                bit l;
                e = q_data.pop_front();
                l = q_last.pop_front();
                check("pixel", int'(bus.output_data), e);
                check("frame_done", int'(bus.frame_done), int'(l));
            end
            if (!seen_first) begin first_cyc = cyc; seen_first = 1; end
        end
        if (bus.frame_done) fd_cnt++;
    end

    initial begin
        resetn               = 1'b0;
        bus.input_data       = '0;
        bus.input_data_valid = 1'b0;
`ifdef SOBEL_THRESHOLD_EN
        bus.threshold = 8'(thr);
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_data", int'(bus.output_data), 0);
        check("rst_out_vld", int'(bus.output_data_valid), 0);
        check("rst_frame_done", int'(bus.frame_done), 0);
        check("rst_overflow", int'(bus.overflow), 0);
        check("rst_ready", int'(bus.input_ready), 1);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Flat frame followed back to back by the vertical step frame.
        fill_flat(100);
        seen_first = 0;
        send_frame(0, 1'b0, NPIX);
        check("latency", first_cyc - acc_cyc, 2);
        fill_step(0, 255);
        send_frame(0, 1'b0, NPIX);
        drain_wait();
        check("no_overflow", int'(bus.overflow), 0);

        // Random pixels with input gaps.
        repeat (3) begin
            fill_rand();
            send_frame(30, 1'b0, NPIX);
        end
        drain_wait();

        // Valid held while draining: dropped pixels, sticky overflow.
        fill_rand();
        send_frame(0, 1'b1, NPIX);
        drain_wait();
        check("overflow_set", int'(bus.overflow), 1);
        fill_flat(7);
        send_frame(10, 1'b0, NPIX);
        drain_wait();
        check("overflow_sticky", int'(bus.overflow), 1);

        // Reset in the middle of a frame, then a clean frame.
        mon_en = 0;
        fill_rand();
        send_frame(0, 1'b0, 20);
        resetn = 1'b0;
        #1;
        check("mid_rst_vld", int'(bus.output_data_valid), 0);
        check("mid_rst_data", int'(bus.output_data), 0);
        check("mid_rst_overflow", int'(bus.overflow), 0);
        check("mid_rst_ready", int'(bus.input_ready), 1);
        @(posedge clk); #1;
        resetn = 1'b1;
        mon_en = 1;
        @(posedge clk); #1;
        fill_step(0, 255);
        send_frame(0, 1'b0, NPIX);
        drain_wait();

`ifdef SOBEL_THRESHOLD_EN
        thr = 128;
        bus.threshold = 8'(thr);
        fill_step(0, 255);
        send_frame(0, 1'b0, NPIX);
        drain_wait();
        thr = 255;
        bus.threshold = 8'(thr);
        fill_step(0, 20);
        send_frame(0, 1'b0, NPIX);
        drain_wait();
`endif

        check("frame_count", fd_cnt, frames_exp);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
